mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control unit.
// The instruction register holds op/funct for the whole instruction. Because of
// that, every output is a purely combinational decode of the current state, op,
// funct and zero. Only one instruction is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high; state returns to FETCH at once
//   op, funct  IR[31:26], IR[5:0]
//   zero       ALU result == 0, used by beq in EXE
//   PCWr, IRWr, RegWr, MemWr   write enables
//   ALUOp      000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra
//   ALUSrcA    0 rs, 1 rt
//   ALUSrcB    00 rt, 01 extended imm, 10 shamt
//   EXTOp      00 zero-ext, 01 sign-ext, 10 imm<<16
//   RegDst     00 rt, 01 rd, 10 $31
//   WDSel      00 ALU, 01 memory, 10 PC
//   NPCOp      00 PC+4, 01 branch, 10 j/jal, 11 jr
//   state      FETCH 0, DECODE 1, EXE 2, MEM 3, WB 4
//   illegal    one-cycle pulse in DECODE for an unsupported encoding
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic       MemWr,
  output logic [2:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] EXTOp,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic [2:0] state,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  state_t state_q, state_d;

  // Instruction decode
  logic is_r, i_addu, i_subu, i_and, i_or, i_srl, i_sra, i_jr;
  logic i_ori, i_lui, i_lw, i_sw, i_beq, i_j, i_jal;
  logic r_alu, legal;

  always_comb begin
    is_r   = (op == OP_R);
    i_addu = is_r && (funct == FN_ADDU);
    i_subu = is_r && (funct == FN_SUBU);
    i_and  = is_r && (funct == FN_AND);
    i_or   = is_r && (funct == FN_OR);
    i_srl  = is_r && (funct == FN_SRL);
    i_sra  = is_r && (funct == FN_SRA);
    i_jr   = is_r && (funct == FN_JR);
    i_ori  = (op == OP_ORI);
    i_lui  = (op == OP_LUI);
    i_lw   = (op == OP_LW);
    i_sw   = (op == OP_SW);
    i_beq  = (op == OP_BEQ);
    i_j    = (op == OP_J);
    i_jal  = (op == OP_JAL);
    r_alu  = i_addu | i_subu | i_and | i_or | i_srl | i_sra;
    legal  = r_alu | i_jr | i_ori | i_lui | i_lw | i_sw | i_beq | i_j | i_jal;
  end

  // Datapath operand/ALU selection. This depends only on the held instruction,
  // so it is driven unchanged through EXE, MEM and WB.
  logic [2:0] alu_op_c;
  logic       src_a_c;
  logic [1:0] src_b_c, ext_c;

  always_comb begin
    alu_op_c = 3'b000;
    src_a_c  = 1'b0;
    src_b_c  = 2'b00;
    ext_c    = 2'b00;
    if (i_subu || i_beq) alu_op_c = 3'b001;
    if (i_and)           alu_op_c = 3'b010;
    if (i_or || i_ori)   alu_op_c = 3'b011;
    if (i_srl)           alu_op_c = 3'b100;
    if (i_sra)           alu_op_c = 3'b101;
    if (i_srl || i_sra) begin
      src_a_c = 1'b1;
      src_b_c = 2'b10;
    end
    if (i_ori || i_lui || i_lw || i_sw) src_b_c = 2'b01;
    if (i_lw || i_sw || i_beq)          ext_c   = 2'b01;
    if (i_lui)                          ext_c   = 2'b10;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  logic pc_wr_c, ir_wr_c, reg_wr_c, mem_wr_c, ill_c;

  always_comb begin
    state_d  = S_FETCH;
    pc_wr_c  = 1'b0;
    ir_wr_c  = 1'b0;
    reg_wr_c = 1'b0;
    mem_wr_c = 1'b0;
    ill_c    = 1'b0;
    ALUOp    = '0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = '0;
    EXTOp    = '0;
    RegDst   = '0;
    WDSel    = '0;
    NPCOp    = '0;
    case (state_q)
      S_FETCH: begin
        pc_wr_c = 1'b1;
        ir_wr_c = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (i_j) begin
          pc_wr_c = 1'b1;
          NPCOp   = 2'b10;
        end else if (i_jal) begin
          pc_wr_c  = 1'b1;
          NPCOp    = 2'b10;
          reg_wr_c = 1'b1;
          RegDst   = 2'b10;
          WDSel    = 2'b10;
        end else if (i_jr) begin
          pc_wr_c = 1'b1;
          NPCOp   = 2'b11;
        end else if (!legal) begin
          ill_c = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        ALUOp   = alu_op_c;
        ALUSrcA = src_a_c;
        ALUSrcB = src_b_c;
        EXTOp   = ext_c;
        if (i_beq) begin
          pc_wr_c = zero;
          NPCOp   = 2'b01;
        end else if (i_lw || i_sw) begin
          state_d = S_MEM;
        end else if (r_alu || i_ori || i_lui) begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ALUOp    = alu_op_c;
        ALUSrcA  = src_a_c;
        ALUSrcB  = src_b_c;
        EXTOp    = ext_c;
        mem_wr_c = i_sw;
        if (i_lw) state_d = S_WB;
      end
      S_WB: begin
        ALUOp    = alu_op_c;
        ALUSrcA  = src_a_c;
        ALUSrcB  = src_b_c;
        EXTOp    = ext_c;
        reg_wr_c = 1'b1;
        if (r_alu)     RegDst = 2'b01;
        else if (i_lw) WDSel  = 2'b01;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // The register alone would leave FETCH's PCWr/IRWr high while reset is held.
  // The enables are therefore gated directly with reset.
  assign PCWr    = pc_wr_c  & ~reset;
  assign IRWr    = ir_wr_c  & ~reset;
  assign RegWr   = reg_wr_c & ~reset;
  assign MemWr   = mem_wr_c & ~reset;
  assign illegal = ill_c    & ~reset;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomised bench for mc_ctrl.
// The model describes each instruction by its architectural attributes: CPI,
// ALU controls and writeback routing. It derives the expected per-cycle outputs
// from those attributes.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       PCWr, IRWr, RegWr, MemWr, ALUSrcA, illegal;
  logic [2:0] ALUOp, state;
  logic [1:0] ALUSrcB, EXTOp, RegDst, WDSel, NPCOp;

  int errs = 0;
  int checks = 0;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp),
    .RegDst(RegDst), .WDSel(WDSel), .NPCOp(NPCOp), .state(state),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction kinds:
  // 0 addu 1 subu 2 and 3 or 4 srl 5 sra 6 jr 7 ori 8 lui 9 lw 10 sw 11 beq
  // 12 j 13 jal 14 illegal
  typedef struct packed {
    logic [5:0] op;
    logic [5:0] funct;
    logic [2:0] cpi;
    logic [2:0] aluop;
    logic       asrc;
    logic [1:0] bsrc;
    logic [1:0] ext;
    logic [1:0] dst;
    logic [1:0] wsel;
  } ins_t;

  function automatic ins_t info(input int k);
    case (k)
      0:  info = '{6'h00, 6'h21, 3'd4, 3'b000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00};
      1:  info = '{6'h00, 6'h23, 3'd4, 3'b001, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00};
      2:  info = '{6'h00, 6'h24, 3'd4, 3'b010, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00};
      3:  info = '{6'h00, 6'h25, 3'd4, 3'b011, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00};
      4:  info = '{6'h00, 6'h02, 3'd4, 3'b100, 1'b1, 2'b10, 2'b00, 2'b01, 2'b00};
      5:  info = '{6'h00, 6'h03, 3'd4, 3'b101, 1'b1, 2'b10, 2'b00, 2'b01, 2'b00};
      6:  info = '{6'h00, 6'h08, 3'd2, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
      7:  info = '{6'h0D, 6'h00, 3'd4, 3'b011, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
      8:  info = '{6'h0F, 6'h00, 3'd4, 3'b000, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00};
      9:  info = '{6'h23, 6'h00, 3'd5, 3'b000, 1'b0, 2'b01, 2'b01, 2'b00, 2'b01};
      10: info = '{6'h2B, 6'h00, 3'd4, 3'b000, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00};
      11: info = '{6'h04, 6'h00, 3'd3, 3'b001, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00};
      12: info = '{6'h02, 6'h00, 3'd2, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
      13: info = '{6'h03, 6'h00, 3'd2, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
      default: info = '{6'h3F, 6'h3F, 3'd2, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
    endcase
  endfunction

  function automatic string name(input int k);
    case (k)
      0: name = "addu"; 1: name = "subu"; 2: name = "and"; 3: name = "or";
      4: name = "srl"; 5: name = "sra"; 6: name = "jr"; 7: name = "ori";
      8: name = "lui"; 9: name = "lw"; 10: name = "sw"; 11: name = "beq";
      12: name = "j"; 13: name = "jal"; default: name = "illegal";
    endcase
  endfunction

  // State visited on step n of an instruction: only loads and stores use MEM.
  function automatic logic [2:0] exp_state(input int k, input int n);
    case (n)
      0: exp_state = 3'd0;
      1: exp_state = 3'd1;
      2: exp_state = 3'd2;
      3: exp_state = (k == 9 || k == 10) ? 3'd3 : 3'd4;
      default: exp_state = 3'd4;
    endcase
  endfunction

  function automatic logic [21:0] exp_out(input int k, input logic [2:0] st, input logic z);
    ins_t d = info(k);
    logic pc = 0, ir = 0, rw = 0, mw = 0, ill = 0, as = 0;
    logic [2:0] alu = '0;
    logic [1:0] bs = '0, ex = '0, dst = '0, ws = '0, npc = '0;
    if (st >= 3'd2) begin
      alu = d.aluop; as = d.asrc; bs = d.bsrc; ex = d.ext;
    end
    case (st)
      3'd0: begin pc = 1; ir = 1; end
      3'd1: begin
        if (k == 12) begin pc = 1; npc = 2'b10; end
        if (k == 13) begin pc = 1; npc = 2'b10; rw = 1; dst = 2'b10; ws = 2'b10; end
        if (k == 6)  begin pc = 1; npc = 2'b11; end
        if (k == 14) ill = 1;
      end
      3'd2: if (k == 11) begin pc = z; npc = 2'b01; end
      3'd3: if (k == 10) mw = 1;
      3'd4: begin rw = 1; dst = d.dst; ws = d.wsel; end
      default: ;
    endcase
    exp_out = {pc, ir, rw, mw, alu, as, bs, ex, dst, ws, npc, st, ill};
  endfunction

  function automatic logic [21:0] dut_out();
    dut_out = {PCWr, IRWr, RegWr, MemWr, ALUOp, ALUSrcA, ALUSrcB, EXTOp,
               RegDst, WDSel, NPCOp, state, illegal};
  endfunction

  function automatic logic supported_op(input logic [5:0] o);
    supported_op = (o == 6'h00 || o == 6'h0D || o == 6'h0F || o == 6'h23 ||
                    o == 6'h2B || o == 6'h04 || o == 6'h02 || o == 6'h03);
  endfunction

  function automatic logic supported_fn(input logic [5:0] f);
    supported_fn = (f == 6'h21 || f == 6'h23 || f == 6'h24 || f == 6'h25 ||
                    f == 6'h02 || f == 6'h03 || f == 6'h08);
  endfunction

  // Presents the encoding of instruction k. Non-R instructions get a random
  // funct. Illegal encodings are either an unknown op or an R-type with an
  // unknown funct.
  task automatic drive(input int k, input logic z);
    ins_t d = info(k);
    zero = z;
    if (k == 14) begin
      if ($urandom_range(0, 1) == 0) begin
        op = 6'h00;
        do funct = 6'($urandom); while (supported_fn(funct));
      end else begin
        do op = 6'($urandom); while (supported_op(op));
        funct = 6'($urandom);
      end
    end else begin
      op = d.op;
      funct = (d.op == 6'h00) ? d.funct : 6'($urandom);
    end
  endtask

  // Entry/exit: between a falling and a rising edge, with the DUT in FETCH.
  task automatic run_instr(input int k, input logic z);
    ins_t d = info(k);
    int cyc = 0;
    int irw = 0;
    drive(k, z);
    #1;
    while (1) begin
      if (cyc < int'(d.cpi))
        chk({name(k), "_step"}, 32'(dut_out()), 32'(exp_out(k, exp_state(k, cyc), z)));
      irw += int'(IRWr);
      cyc++;
      @(negedge clk);
      #1;
      if (state == 3'd0 || cyc >= 8) break;
    end
    chk({name(k), "_cycles"}, 32'(cyc), 32'(d.cpi));
    chk({name(k), "_irwr"}, 32'(irw), 32'd1);
  endtask

  // Starts instruction k and asserts reset mid-cycle during step n.
  task automatic abort_instr(input int k, input logic z, input int n);
    drive(k, z);
    #1;
    repeat (n) @(negedge clk);
    #1;
    chk({name(k), "_pre_rst"}, 32'(dut_out()), 32'(exp_out(k, exp_state(k, n), z)));
    #1;
    reset = 1'b1;
    #1;
    chk("rst_async", 32'(dut_out()), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold", 32'(dut_out()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_release", 32'(dut_out()), 32'(exp_out(k, 3'd0, z)));
  endtask

  initial begin
    reset = 1'b1;
    op = '0;
    funct = '0;
    zero = 1'b0;
    #3;
    chk("reset_nclk", 32'(dut_out()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_clk", 32'(dut_out()), 32'd0);
    reset = 1'b0;
    #1;
    chk("release", 32'(dut_out()), 32'(exp_out(0, 3'd0, 1'b0)));

    // Directed sequence: lw, beq with and without zero, jal, sra, illegal.
    run_instr(9, 1'b0);
    run_instr(11, 1'b1);
    run_instr(11, 1'b0);
    run_instr(13, 1'b0);
    run_instr(5, 1'b0);
    op = 6'h00;
    funct = 6'h3F;
    #1;
    chk("ill_fetch", 32'(dut_out()), 32'(exp_out(14, 3'd0, 1'b0)));
    @(negedge clk);
    #1;
    chk("ill_decode", 32'(dut_out()), 32'(exp_out(14, 3'd1, 1'b0)));
    @(negedge clk);
    #1;
    chk("ill_back", 32'(state), 32'd0);
    chk("ill_pulse", 32'(illegal), 32'd0);

    // Reset in MEM of a store, then another store must complete normally.
    abort_instr(10, 1'b0, 3);
    run_instr(10, 1'b0);
    abort_instr(9, 1'b1, 4);
    run_instr(0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      int k = $urandom_range(0, 14);
      logic z = 1'($urandom_range(0, 1));
      if (i % 25 == 24) begin
        int n = $urandom_range(0, int'(info(k).cpi) - 1);
        abort_instr(k, z, n);
      end else begin
        run_instr(k, z);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
